// File: rtl/cpu_ctrl_pkg.sv
// Shared types and constants for the mini-CPU hardwired control unit:
// FSM states, opcode map, ALU codes and instruction classes.
package cpu_ctrl_pkg;

  localparam int OP_W = 5;
  localparam int IR_W = 32;

  typedef enum logic [2:0] {
    ST_RESET = 3'd0,
    ST_T0    = 3'd1,
    ST_T1    = 3'd2,
    ST_T2    = 3'd3,
    ST_T3    = 3'd4,
    ST_T4    = 3'd5,
    ST_T5    = 3'd6,
    ST_HALT  = 3'd7
  } state_e;

  typedef enum logic [2:0] {
    CLS_R    = 3'd0,
    CLS_I    = 3'd1,
    CLS_NOP  = 3'd2,
    CLS_HALT = 3'd3,
    CLS_ILL  = 3'd4
  } instr_class_e;

  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_SHR  = 5'b00101;
  localparam logic [4:0] OP_SHRA = 5'b00110;
  localparam logic [4:0] OP_SHL  = 5'b00111;
  localparam logic [4:0] OP_ROR  = 5'b01000;
  localparam logic [4:0] OP_AND  = 5'b01001;
  localparam logic [4:0] OP_OR   = 5'b01010;
  localparam logic [4:0] OP_ROL  = 5'b01011;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_ANDI = 5'b01101;
  localparam logic [4:0] OP_ORI  = 5'b01110;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  localparam logic [4:0] ALU_NONE = 5'b00000;
  localparam logic [4:0] ALU_ADD  = 5'b00011;
  localparam logic [4:0] ALU_AND  = 5'b01001;
  localparam logic [4:0] ALU_OR   = 5'b01010;

  typedef struct packed {
    logic       pc_out;
    logic       zlow_out;
    logic       mdr_out;
    logic       c_out;
    logic       r_out;
    logic       mar_in;
    logic       z_in;
    logic       pc_in;
    logic       mdr_in;
    logic       ir_in;
    logic       y_in;
    logic       r_in;
    logic       gra;
    logic       grb;
    logic       grc;
    logic       inc_pc;
    logic       read;
    logic [4:0] operation;
    logic       run;
  } ctrl_t;

  function automatic logic is_r_type(input logic [4:0] op);
    return (op >= OP_ADD) && (op <= OP_ROL);
  endfunction

endpackage

// File: rtl/control_unit_if.sv
// Control-unit <-> datapath signal bundle: instruction word and halt request
// in, bus/register strobes and status out.
interface control_unit_if #(
  parameter int IR_W = 32,
  parameter int OP_W = 5
);
  logic [IR_W-1:0] IR;
  logic            Stop;
  logic            PCout, Zlowout, MDRout, Cout, Rout;
  logic            MARin, Zin, PCin, MDRin, IRin, Yin, Rin;
  logic            Gra, Grb, Grc;
  logic            IncPC, Read;
  logic [OP_W-1:0] Operation;
  logic            Run, Illegal;

  modport master (
    input  IR, Stop,
    output PCout, Zlowout, MDRout, Cout, Rout,
           MARin, Zin, PCin, MDRin, IRin, Yin, Rin,
           Gra, Grb, Grc, IncPC, Read, Operation, Run, Illegal
  );

  modport slave (
    output IR, Stop,
    input  PCout, Zlowout, MDRout, Cout, Rout,
           MARin, Zin, PCin, MDRin, IRin, Yin, Rin,
           Gra, Grb, Grc, IncPC, Read, Operation, Run, Illegal
  );
endinterface

// File: rtl/control_unit_opcode_decode.sv
// Combinational opcode decoder: instruction class plus the ALU operation
// the execute phase should request.
module opcode_decode
  import cpu_ctrl_pkg::*;
#(
  parameter int OP_W = 5
) (
  input  logic [OP_W-1:0] opcode,
  output instr_class_e    cls,
  output logic [OP_W-1:0] alu_op
);

  // Classify the opcode; immediate forms reuse the matching register-form ALU code
  always_comb begin
    cls    = CLS_ILL;
    alu_op = ALU_NONE;
    if (is_r_type(opcode)) begin
      cls    = CLS_R;
      alu_op = opcode;
    end else begin
      case (opcode)
        OP_ADDI: begin cls = CLS_I; alu_op = ALU_ADD; end
        OP_ANDI: begin cls = CLS_I; alu_op = ALU_AND; end
        OP_ORI:  begin cls = CLS_I; alu_op = ALU_OR;  end
        OP_NOP:  cls = CLS_NOP;
        OP_HALT: cls = CLS_HALT;
        default: cls = CLS_ILL;
      endcase
    end
  end

endmodule

// File: rtl/control_unit.sv
// Hardwired Moore sequencer for the mini-CPU datapath: fetch T0-T2, execute
// T3-T5, with strobes registered from the state so they lag it by one clock.
module control_unit
  import cpu_ctrl_pkg::*;
#(
  parameter int OP_W = 5,
  parameter int IR_W = 32
) (
  input  logic           Clock,
  input  logic           Clear,
  control_unit_if.master cu
);

  state_e          state_q, state_d;
  ctrl_t           ctrl_q, ctrl_d;
  logic            illegal_q, illegal_d;
  instr_class_e    cls_s;
  logic [OP_W-1:0] alu_op_s;
  logic            reg_op_s;
  logic            unused_ir_s;

  opcode_decode #(.OP_W(OP_W)) u_decode (
    .opcode (cu.IR[IR_W-1 -: OP_W]),
    .cls    (cls_s),
    .alu_op (alu_op_s)
  );

  assign unused_ir_s = ^cu.IR[IR_W-OP_W-1:0];
  assign reg_op_s    = (cls_s == CLS_R) || (cls_s == CLS_I);

  // Next state; Stop only matters at the two instruction-boundary states
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RESET: state_d = ST_T0;
      ST_T0:    state_d = ST_T1;
      ST_T1:    state_d = ST_T2;
      ST_T2:    state_d = ST_T3;
      ST_T3: begin
        case (cls_s)
          CLS_R, CLS_I: state_d = ST_T4;
          CLS_HALT:     state_d = ST_HALT;
          default:      state_d = cu.Stop ? ST_HALT : ST_T0;
        endcase
      end
      ST_T4:    state_d = ST_T5;
      ST_T5:    state_d = cu.Stop ? ST_HALT : ST_T0;
      ST_HALT:  state_d = ST_HALT;
      default:  state_d = ST_RESET;
    endcase
  end

  // Sticky illegal-opcode flag, raised when the bad opcode is decoded
  always_comb begin
    if ((state_q == ST_T3) && (cls_s == CLS_ILL)) begin
      illegal_d = 1'b1;
    end else begin
      illegal_d = illegal_q;
    end
  end

  // Strobe decode from the current state; registered below
  always_comb begin
    ctrl_d = '0;
    case (state_q)
      ST_T0: begin
        ctrl_d.pc_out = 1'b1;
        ctrl_d.mar_in = 1'b1;
        ctrl_d.inc_pc = 1'b1;
        ctrl_d.z_in   = 1'b1;
        ctrl_d.run    = 1'b1;
      end
      ST_T1: begin
        ctrl_d.zlow_out = 1'b1;
        ctrl_d.pc_in    = 1'b1;
        ctrl_d.read     = 1'b1;
        ctrl_d.mdr_in   = 1'b1;
        ctrl_d.run      = 1'b1;
      end
      ST_T2: begin
        ctrl_d.mdr_out = 1'b1;
        ctrl_d.ir_in   = 1'b1;
        ctrl_d.run     = 1'b1;
      end
      ST_T3: begin
        ctrl_d.grb   = reg_op_s;
        ctrl_d.r_out = reg_op_s;
        ctrl_d.y_in  = reg_op_s;
        ctrl_d.run   = 1'b1;
      end
      ST_T4: begin
        ctrl_d.grc       = (cls_s == CLS_R);
        ctrl_d.r_out     = (cls_s == CLS_R);
        ctrl_d.c_out     = (cls_s == CLS_I);
        ctrl_d.operation = alu_op_s;
        ctrl_d.z_in      = 1'b1;
        ctrl_d.run       = 1'b1;
      end
      ST_T5: begin
        ctrl_d.zlow_out = 1'b1;
        ctrl_d.gra      = 1'b1;
        ctrl_d.r_in     = 1'b1;
        ctrl_d.run      = 1'b1;
      end
      default: ctrl_d = '0;
    endcase
  end

  // State, strobe and flag registers; Clear wipes all of them in one edge
  always_ff @(posedge Clock) begin
    if (Clear) begin
      state_q   <= ST_RESET;
      ctrl_q    <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ctrl_q    <= ctrl_d;
      illegal_q <= illegal_d;
    end
  end

  assign cu.PCout     = ctrl_q.pc_out;
  assign cu.Zlowout   = ctrl_q.zlow_out;
  assign cu.MDRout    = ctrl_q.mdr_out;
  assign cu.Cout      = ctrl_q.c_out;
  assign cu.Rout      = ctrl_q.r_out;
  assign cu.MARin     = ctrl_q.mar_in;
  assign cu.Zin       = ctrl_q.z_in;
  assign cu.PCin      = ctrl_q.pc_in;
  assign cu.MDRin     = ctrl_q.mdr_in;
  assign cu.IRin      = ctrl_q.ir_in;
  assign cu.Yin       = ctrl_q.y_in;
  assign cu.Rin       = ctrl_q.r_in;
  assign cu.Gra       = ctrl_q.gra;
  assign cu.Grb       = ctrl_q.grb;
  assign cu.Grc       = ctrl_q.grc;
  assign cu.IncPC     = ctrl_q.inc_pc;
  assign cu.Read      = ctrl_q.read;
  assign cu.Operation = ctrl_q.operation;
  assign cu.Run       = ctrl_q.run;
  assign cu.Illegal   = illegal_q;

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: a phase-level reference model checks
// every cycle; a vector table and directed sequences cover the corner cases.
module tb_control_unit;

  localparam int P_RST  = 0;
  localparam int P_T0   = 1;
  localparam int P_T1   = 2;
  localparam int P_T2   = 3;
  localparam int P_T3   = 4;
  localparam int P_T4   = 5;
  localparam int P_T5   = 6;
  localparam int P_HALT = 7;

  localparam int C_R = 0, C_I = 1, C_NOP = 2, C_HALT = 3, C_ILL = 4;

  typedef struct packed {
    logic pcout, zlowout, mdrout, cout, rout;
    logic marin, zin, pcin, mdrin, irin, yin, rin;
    logic gra, grb, grc, incpc, read;
    logic [4:0] operation;
    logic run, illegal;
  } obs_t;

  typedef struct {
    logic [31:0] ir;
    int          exp_len;
    logic        exp_ill;
  } vec_t;

  logic Clock = 1'b0;
  logic Clear;
  int   errors = 0;
  int   checks = 0;

  // reference model: visible phase, pending boundary decision, sticky flag
  int   vph;
  bit   rst_hold;
  bit   dec_halt;
  bit   ill_m;

  control_unit_if #(.IR_W(32), .OP_W(5)) cu_if ();

  control_unit #(.OP_W(5), .IR_W(32)) dut (
    .Clock (Clock),
    .Clear (Clear),
    .cu    (cu_if)
  );

  always #5 Clock = ~Clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic int cls_of(input logic [4:0] op);
    int v;
    v = int'(op);
    if (v >= 3 && v <= 11) return C_R;
    if (v >= 12 && v <= 14) return C_I;
    if (v == 26) return C_NOP;
    if (v == 27) return C_HALT;
    return C_ILL;
  endfunction

  function automatic logic [4:0] aluop_of(input logic [4:0] op);
    logic [4:0] r;
    case (cls_of(op))
      C_R:     r = op;
      C_I:     r = (op == 5'd12) ? 5'd3 : ((op == 5'd13) ? 5'd9 : 5'd10);
      default: r = 5'd0;
    endcase
    return r;
  endfunction

  function automatic obs_t expect_obs(input int ph, input logic [4:0] op, input logic ill);
    obs_t e;
    int   c;
    e = '0;
    c = cls_of(op);
    e.illegal = ill;
    e.run     = (ph >= P_T0) && (ph <= P_T5);
    case (ph)
      P_T0: begin e.pcout = 1'b1; e.marin = 1'b1; e.incpc = 1'b1; e.zin = 1'b1; end
      P_T1: begin e.zlowout = 1'b1; e.pcin = 1'b1; e.read = 1'b1; e.mdrin = 1'b1; end
      P_T2: begin e.mdrout = 1'b1; e.irin = 1'b1; end
      P_T3: if (c == C_R || c == C_I) begin e.grb = 1'b1; e.rout = 1'b1; e.yin = 1'b1; end
      P_T4: begin
        e.zin       = 1'b1;
        e.operation = aluop_of(op);
        if (c == C_R) begin e.grc = 1'b1; e.rout = 1'b1; end
        else          e.cout = 1'b1;
      end
      P_T5: begin e.zlowout = 1'b1; e.gra = 1'b1; e.rin = 1'b1; end
      default: ;
    endcase
    return e;
  endfunction

  function automatic obs_t observe();
    obs_t o;
    o.pcout = cu_if.PCout;   o.zlowout = cu_if.Zlowout; o.mdrout = cu_if.MDRout;
    o.cout  = cu_if.Cout;    o.rout    = cu_if.Rout;    o.marin  = cu_if.MARin;
    o.zin   = cu_if.Zin;     o.pcin    = cu_if.PCin;    o.mdrin  = cu_if.MDRin;
    o.irin  = cu_if.IRin;    o.yin     = cu_if.Yin;     o.rin    = cu_if.Rin;
    o.gra   = cu_if.Gra;     o.grb     = cu_if.Grb;     o.grc    = cu_if.Grc;
    o.incpc = cu_if.IncPC;   o.read    = cu_if.Read;    o.operation = cu_if.Operation;
    o.run   = cu_if.Run;     o.illegal = cu_if.Illegal;
    return o;
  endfunction

  // Advance the visible phase by one clock. Strobes trail the state register
  // by a clock, so the Stop decision is taken on the edge that starts the
  // final visible execute phase (T5, or T3 of a nop/illegal instruction).
  task automatic model_edge(input logic clr, input logic stp, input logic [4:0] op);
    int c;
    c = cls_of(op);
    if (clr) begin
      vph = P_RST; rst_hold = 1'b1; ill_m = 1'b0;
    end else begin
      case (vph)
        P_RST:  if (rst_hold) rst_hold = 1'b0; else vph = P_T0;
        P_T0:   vph = P_T1;
        P_T1:   vph = P_T2;
        P_T2: begin
          vph = P_T3;
          if (c == C_ILL) ill_m = 1'b1;
          if (c == C_NOP || c == C_ILL) dec_halt = stp;
        end
        P_T3: begin
          if (c == C_R || c == C_I) vph = P_T4;
          else if (c == C_HALT)     vph = P_HALT;
          else                      vph = dec_halt ? P_HALT : P_T0;
        end
        P_T4:   begin vph = P_T5; dec_halt = stp; end
        P_T5:   vph = dec_halt ? P_HALT : P_T0;
        default: vph = P_HALT;
      endcase
    end
  endtask

  task automatic cycle(input string name);
    obs_t got, exp;
    @(posedge Clock);
    model_edge(Clear, cu_if.Stop, cu_if.IR[31:27]);
    @(negedge Clock);
    got = observe();
    exp = expect_obs(vph, cu_if.IR[31:27], ill_m);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: phase=%0d got=%h expected=%h", name, vph, got, exp);
    end
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h", name, got, exp);
    end
  endtask

  task automatic restart();
    Clear = 1'b1;
    cycle("restart_clear");
    Clear = 1'b0;
    cycle("restart_rst");
    cycle("restart_t0");
    chk("restart_run", {31'd0, cu_if.Run}, 32'd1);
  endtask

  function automatic logic [31:0] mk_ir(input logic [4:0] op);
    logic [26:0] low;
    low = 27'($urandom);
    return {op, low};
  endfunction

  vec_t tbl[11];
  int   n;

  initial begin
    tbl[0]  = '{32'h4A920000, 6, 1'b0};               // and R5,R2,R4
    tbl[1]  = '{{5'b01101, 27'h0124_0010}, 6, 1'b0};  // andi
    tbl[2]  = '{{5'b01100, 27'h0124_0010}, 6, 1'b0};  // addi
    tbl[3]  = '{{5'b01110, 27'h0124_0010}, 6, 1'b0};  // ori
    tbl[4]  = '{{5'b00100, 27'h0491_8000}, 6, 1'b0};  // sub
    tbl[5]  = '{{5'b00011, 27'h0491_8000}, 6, 1'b0};  // add, low edge of R range
    tbl[6]  = '{{5'b01011, 27'h0491_8000}, 6, 1'b0};  // rol, high edge of R range
    tbl[7]  = '{{5'b11010, 27'h0000_0000}, 4, 1'b0};  // nop
    tbl[8]  = '{{5'b11111, 27'h0491_8000}, 4, 1'b1};  // undefined
    tbl[9]  = '{{5'b01111, 27'h0000_0000}, 4, 1'b1};  // just past ori
    tbl[10] = '{{5'b00010, 27'h0000_0000}, 4, 1'b1};  // just below add

    cu_if.IR   = 32'h0;
    cu_if.Stop = 1'b0;
    Clear      = 1'b1;
    vph = P_RST; rst_hold = 1'b1; dec_halt = 1'b0; ill_m = 1'b0;

    // reset and release
    cycle("reset0");
    cycle("reset1");
    Clear = 1'b0;
    cycle("release_rst");
    chk("run_low_in_reset", {31'd0, cu_if.Run}, 32'd0);
    cycle("release_t0");
    chk("run_rises_t0", {31'd0, cu_if.Run}, 32'd1);

    // table-driven instructions, each started at visible T0
    for (int i = 0; i < 11; i++) begin
      cu_if.IR = tbl[i].ir;
      n = 0;
      do begin
        cycle($sformatf("tbl%0d", i));
        n++;
      end while (vph != P_T0 && n < 12);
      chk($sformatf("tbl%0d_len", i), n, tbl[i].exp_len);
      chk($sformatf("tbl%0d_illegal", i), {31'd0, cu_if.Illegal}, {31'd0, tbl[i].exp_ill});
    end

    // Stop pulse during T2 of an ALU op: no halt
    cu_if.IR = 32'h4A920000;
    cycle("p2_t1");
    cycle("p2_t2");
    cu_if.Stop = 1'b1;
    cycle("p2_t3");
    cu_if.Stop = 1'b0;
    cycle("p2_t4");
    cycle("p2_t5");
    cycle("p2_t0");
    chk("p2_no_halt", {30'd0, cu_if.Run, cu_if.PCout}, 32'd3);

    // Clear during T4 of andi
    cu_if.IR = {5'b01101, 27'h0124_0010};
    for (int k = 0; k < 4; k++) cycle("c4_pre");
    chk("andi_t4_cout", {31'd0, cu_if.Cout}, 32'd1);
    chk("andi_t4_rout", {31'd0, cu_if.Rout}, 32'd0);
    chk("andi_t4_op", {27'd0, cu_if.Operation}, 32'd9);
    Clear = 1'b1;
    cycle("c4_clear");
    chk("c4_illegal", {31'd0, cu_if.Illegal}, 32'd0);
    chk("c4_strobes", {28'd0, cu_if.Zin, cu_if.Cout, cu_if.Run, cu_if.Rin}, 32'd0);
    Clear = 1'b0;
    cycle("c4_rst");
    cycle("c4_t0");

    // nop then halt, HALT held 20 clocks, Clear restarts
    cu_if.IR = {5'b11010, 27'h0};
    n = 0;
    do begin cycle("nop"); n++; end while (vph != P_T0 && n < 12);
    chk("nop_len", n, 4);
    cu_if.IR = {5'b11011, 27'h0};
    n = 0;
    do begin cycle("halt"); n++; end while (vph != P_HALT && n < 12);
    chk("halt_len", n, 4);
    for (int k = 0; k < 20; k++) begin
      cycle("halt_hold");
      chk("halt_run_low", {31'd0, cu_if.Run}, 32'd0);
    end
    restart();

    // Stop raised in T4 and held 3 clocks
    cu_if.IR = 32'h4A920000;
    for (int k = 0; k < 4; k++) cycle("s4_pre");
    cu_if.Stop = 1'b1;
    cycle("s4_t5");
    cycle("s4_halt0");
    cycle("s4_halt1");
    cu_if.Stop = 1'b0;
    cycle("s4_halt2");
    chk("s4_halted", {31'd0, cu_if.Run}, 32'd0);
    restart();

    // randomized run against the phase model
    for (int k = 0; k < 3000; k++) begin
      int r;
      logic [4:0] op;
      Clear      = ($urandom_range(0, 79) == 0) || (vph == P_HALT && $urandom_range(0, 3) == 0);
      cu_if.Stop = ($urandom_range(0, 7) == 0);
      if (vph == P_T0 || vph == P_RST) begin
        r = $urandom_range(0, 19);
        if (r < 9)       op = 5'(3 + r);
        else if (r < 12) op = 5'(3 + r);
        else if (r < 14) op = 5'b11010;
        else if (r < 15) op = 5'b11011;
        else             op = 5'($urandom);
        cu_if.IR = mk_ir(op);
      end
      cycle("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
